// File: rtl/gate_actuator.sv
// rtl/gate_actuator.sv - gate travel FSM with edge-detected toggle command and inhibit interlock
module gate_actuator #(
   parameter int TRAVEL = 8,
   parameter int PW     = 4
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          OpenClose,
   input  logic          Inhibit,
   output logic          GateOpen,
   output logic          GateClosed,
   output logic          Moving,
   output logic [PW-1:0] Position,
   output logic          Reject
);

   typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

   localparam logic [PW-1:0] POS_OPEN = PW'(TRAVEL);
   localparam logic [PW-1:0] POS_NEAR = PW'(TRAVEL - 1);
   localparam logic [PW-1:0] POS_ONE  = PW'(1);

   state_t        state;
   state_t        state_n;
   logic [PW-1:0] pos_n;
   logic          reject_n;
   logic          OcPrev;
   logic          request;

   assign request = OpenClose & ~OcPrev;

   // Status flags are decoded from the next state so they leave flops together with the state.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= CLOSED;
         Position   <= '0;
         Reject     <= 1'b0;
         OcPrev     <= 1'b0;
         GateClosed <= 1'b1;
         GateOpen   <= 1'b0;
         Moving     <= 1'b0;
      end else begin
         state      <= state_n;
         Position   <= pos_n;
         Reject     <= reject_n;
         OcPrev     <= OpenClose;
         GateClosed <= (state_n == CLOSED);
         GateOpen   <= (state_n == OPEN);
         Moving     <= (state_n == OPENING) || (state_n == CLOSING);
      end
   end

   always_comb begin
      state_n  = state;
      pos_n    = Position;
      reject_n = 1'b0;
      case (state)
         CLOSED: begin
            if (request) begin
               if (Inhibit) reject_n = 1'b1;
               else         state_n  = OPENING;
            end
         end
         OPENING: begin
            if (request || Inhibit) begin
               state_n = CLOSING;
            end else if (Position >= POS_NEAR) begin
               pos_n   = POS_OPEN;
               state_n = OPEN;
            end else begin
               pos_n = Position + POS_ONE;
            end
         end
         OPEN: begin
            if (request) state_n = CLOSING;
         end
         CLOSING: begin
            if (request && !Inhibit) begin
               state_n = OPENING;
            end else begin
               reject_n = request;
               // Saturate at 0: a reversal right after leaving CLOSED can arrive here at 0.
               if (Position <= POS_ONE) begin
                  pos_n   = '0;
                  state_n = CLOSED;
               end else begin
                  pos_n = Position - POS_ONE;
               end
            end
         end
         default: begin
            state_n = CLOSED;
            pos_n   = '0;
         end
      endcase
   end

endmodule

// File: doc/gate_actuator.md
GATE_ACTUATOR -- requirements
Module: gate_actuator

Interface
REQ-001 Parameter: TRAVEL, default 8, gate travel time in clock cycles, full-closed to full-open; legal range 1 to 2^PW-1.
REQ-002 Parameter: PW, default 4, width of Position.
REQ-003 Clock  input  1  single system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 OpenClose  input  1  toggle command from the switch-port block; each rising edge is one request.
REQ-006 Inhibit  input  1  safety interlock; high forbids opening.
REQ-007 GateOpen  output  1  gate fully open.
REQ-008 GateClosed  output  1  gate fully closed.
REQ-009 Moving  output  1  gate travelling in either direction.
REQ-010 Position  output  PW  travel position; 0 = closed, TRAVEL = open.
REQ-011 Reject  output  1  one-cycle pulse; request refused by Inhibit.

Function
REQ-012 Edge detect shall use one register OcPrev; request = OpenClose & ~OcPrev, evaluated combinationally and acted on at the same clock edge.
REQ-013 OpenClose held high shall produce exactly one request; the next request needs a low-then-high transition.
REQ-014 The FSM shall have four states: CLOSED, OPENING, OPEN, CLOSING.
REQ-015 CLOSED, request and Inhibit low: go to OPENING; Position stays 0 on that edge.
REQ-016 CLOSED, request and Inhibit high: stay CLOSED; Reject high for the next cycle only.
REQ-017 OPENING, no request and Inhibit low: Position += 1 each edge; on the edge where Position becomes TRAVEL, the state becomes OPEN.
REQ-018 OPENING, request or Inhibit high: go to CLOSING; Position unchanged on that edge.
REQ-019 A request and Inhibit together in OPENING shall cause one reversal and no Reject.
REQ-020 OPEN, request: go to CLOSING regardless of Inhibit; Position unchanged on that edge.
REQ-021 OPEN, Inhibit alone: no effect.
REQ-022 CLOSING, no request: Position -= 1 each edge; on the edge where Position becomes 0, the state becomes CLOSED.
REQ-023 CLOSING, request and Inhibit low: go to OPENING; Position unchanged.
REQ-024 CLOSING, request and Inhibit high: continue closing; Reject pulses.
REQ-025 Position shall never leave 0..TRAVEL; no wrap-around in either direction.
REQ-026 Outputs shall be registered and glitch-free:
  - GateClosed = state CLOSED
  - GateOpen = state OPEN
  - Moving = state OPENING or CLOSING
  - exactly one of the three shall be high at all times.
REQ-027 Latency, request at edge k from CLOSED with Inhibit low:
  - Moving high after edge k
  - Position = n after edge k+n
  - GateOpen high after edge k+TRAVEL.
REQ-028 Reject shall be high for exactly one cycle per refused request; back-to-back refused requests give separate pulses.

Reset
REQ-029 While Reset is low, the block shall immediately, without waiting for a clock edge, set:
  - state CLOSED, Position 0
  - GateClosed 1, GateOpen 0, Moving 0, Reject 0
  - OcPrev 0.
REQ-030 Reset asserted mid-travel shall abandon the motion; no pending request survives reset.
REQ-031 If OpenClose is high at the first edge after reset release, that edge shall count as a request (OcPrev = 0).

Verification
REQ-032 TRAVEL=8, Inhibit=0, OpenClose pulse at edge k -> Moving=1 after k; Position 1..8 on edges k+1..k+8; GateOpen=1, Moving=0 after k+8.
REQ-033 Closed gate, Inhibit=1, OpenClose pulse -> Reject=1 for exactly one cycle; GateClosed stays 1; Position stays 0.
REQ-034 Opening, second OpenClose pulse at Position=3 -> CLOSING, Position holds 3 on that edge, then 2,1,0; GateClosed=1 on the edge Position reaches 0.
REQ-035 Opening, Inhibit raised at Position=5 -> forced CLOSING, no Reject; closed 5 edges after reversal.
REQ-036 OpenClose held high 20 cycles from closed -> single open sequence; gate stays OPEN; no spurious second request.
REQ-037 Reset pulled low asynchronously at Position=4 while OPENING -> GateClosed=1, Position=0, Moving=0 before the next clock edge.
